// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Imported by the fetch stage and by anything that needs its state names.
package ifu_fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ,
        S_RSP,
        S_OUT,
        S_WAIT
    } state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;

    // Word fetches require a 4-byte aligned address.
    function automatic logic isMisaligned(input logic [1:0] lowBits);
        return lowBits != 2'b00;
    endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Bundle of the fetch unit's memory, decode and next-pc channels.
// master = fetch unit side, slave = memory/decode/execute side.
interface ifu_fetch_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);

    logic                  imem_req_valid;
    logic                  imem_req_ready;
    logic [ADDR_WIDTH-1:0] imem_req_addr;
    logic                  imem_rsp_valid;
    logic                  imem_rsp_ready;
    logic [DATA_WIDTH-1:0] imem_rsp_data;
    logic                  imem_rsp_err;
    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_WIDTH-1:0] out_pc;
    logic [DATA_WIDTH-1:0] out_inst;
    logic                  out_fault;
    logic                  npc_valid;
    logic [ADDR_WIDTH-1:0] npc;
    logic [31:0]           fetch_count;

    modport master (
        output imem_req_valid, imem_req_addr, imem_rsp_ready,
        output out_valid, out_pc, out_inst, out_fault, fetch_count,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        input  out_ready, npc_valid, npc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, imem_rsp_ready,
        input  out_valid, out_pc, out_inst, out_fault, fetch_count,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        output out_ready, npc_valid, npc
    );

endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: one instruction in flight, fetch -> deliver to decode
// -> wait for the retired instruction's next pc.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic       clk,
    input  logic       rst,
    ifu_fetch_if.master bus
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] outPc_q;
    logic [DATA_WIDTH-1:0] outInst_q;
    logic                  outFault_q;
    logic [31:0]           fetchCount_q;
    logic                  pcMisaligned;

    assign pcMisaligned = isMisaligned(pc_q[1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // A misaligned pc never reaches memory; it goes straight to decode as a fault.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ: begin
                if (pcMisaligned) begin
                    state_d = S_OUT;
                end else if (bus.imem_req_ready) begin
                    state_d = S_RSP;
                end
            end
            S_RSP:   if (bus.imem_rsp_valid) state_d = S_OUT;
            S_OUT:   if (bus.out_ready)      state_d = S_WAIT;
            S_WAIT:  if (bus.npc_valid)      state_d = S_REQ;
            default: state_d = S_REQ;
        endcase
    end

    always_comb begin
        bus.imem_req_valid = (state_q == S_REQ) && !pcMisaligned && !rst;
        bus.imem_req_addr  = pc_q;
        bus.imem_rsp_ready = (state_q == S_RSP) && !rst;
        bus.out_valid      = (state_q == S_OUT);
        bus.out_pc         = outPc_q;
        bus.out_inst       = outInst_q;
        bus.out_fault      = outFault_q;
        bus.fetch_count    = fetchCount_q;
    end

    // Payload is captured once on entry to S_OUT so decode sees it stable while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            outPc_q      <= '0;
            outInst_q    <= '0;
            outFault_q   <= 1'b0;
            fetchCount_q <= '0;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (pcMisaligned) begin
                        outPc_q    <= pc_q;
                        outInst_q  <= '0;
                        outFault_q <= 1'b1;
                    end
                end
                S_RSP: begin
                    if (bus.imem_rsp_valid) begin
                        outPc_q    <= pc_q;
                        outInst_q  <= bus.imem_rsp_err ? '0 : bus.imem_rsp_data;
                        outFault_q <= bus.imem_rsp_err;
                    end
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        fetchCount_q <= fetchCount_q + 32'd1;
                    end
                end
                S_WAIT: begin
                    if (bus.npc_valid) begin
                        pc_q <= bus.npc;
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory must only answer a request we actually have outstanding.
    rspOnlyInRsp: assert property (@(posedge clk) disable iff (rst)
        bus.imem_rsp_valid |-> (state_q == S_RSP));

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed sequences, a vector table and
// randomized transactions checked against a transaction-level reference model.
module tb_ifu_fetch;
    import ifu_fetch_pkg::*;

    typedef struct {
        logic [31:0] npc;
        int          memStall;
        int          memLat;
        int          outStall;
        logic [31:0] expPc;
        logic [31:0] expInst;
        logic        expFault;
        int          expReq;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ifu_fetch_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    ifu_fetch #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .RESET_PC  (32'h8000_0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int          checkCount = 0;
    int          passCount  = 0;
    int          cfgStall   = 0;
    int          cfgLat     = 1;
    int          reqCount   = 0;
    int          holdErr    = 0;
    int          expCount   = 0;
    logic [31:0] lastReqAddr = '0;
    vec_t        vecs[8];

    // Memory contents: error region 0xE, a NOP region 0xD, otherwise address-tagged words.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a[15:12] == 4'hE) return 32'hDEAD_BEEF;
        if (a[15:12] == 4'hD) return INST_NOP;
        return {a[15:0], 16'h0413};
    endfunction

    function automatic logic refFault(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[15:12] == 4'hE);
    endfunction

    function automatic logic [31:0] refInst(input logic [31:0] a);
        return refFault(a) ? 32'h0 : memWord(a);
    endfunction

    // Memory responder: drives just after negedge, samples handshakes just before posedge.
    initial begin : memModel
        logic        pending;
        logic        lastReqFire;
        logic        lastRspFire;
        logic        holdReq;
        logic [31:0] lastAddr;
        logic [31:0] pendAddr;
        logic [31:0] heldAddr;
        int          latLeft;
        int          waited;
        pending = 1'b0; lastReqFire = 1'b0; lastRspFire = 1'b0; holdReq = 1'b0;
        lastAddr = '0; pendAddr = '0; heldAddr = '0; latLeft = 0; waited = 0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.imem_rsp_err   = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                pending = 1'b0; latLeft = 0; waited = 0;
                lastReqFire = 1'b0; lastRspFire = 1'b0;
                bus.imem_req_ready = 1'b0;
                bus.imem_rsp_valid = 1'b0;
            end else begin
                if (lastRspFire) begin
                    pending = 1'b0;
                    bus.imem_rsp_valid = 1'b0;
                end
                if (lastReqFire) begin
                    pending = 1'b1; pendAddr = lastAddr; latLeft = cfgLat - 1; waited = 0;
                    reqCount++;
                    lastReqAddr = lastAddr;
                end
                if (!pending && bus.imem_req_valid) begin
                    if (waited >= cfgStall) begin
                        bus.imem_req_ready = 1'b1;
                    end else begin
                        bus.imem_req_ready = 1'b0;
                        waited++;
                    end
                end else begin
                    bus.imem_req_ready = 1'b0;
                end
                if (pending && !bus.imem_rsp_valid) begin
                    if (latLeft > 0) begin
                        latLeft--;
                    end else begin
                        bus.imem_rsp_valid = 1'b1;
                        bus.imem_rsp_data  = memWord(pendAddr);
                        bus.imem_rsp_err   = (pendAddr[15:12] == 4'hE);
                    end
                end
            end
            if (!bus.imem_rsp_valid) begin
                bus.imem_rsp_data = $urandom;
                bus.imem_rsp_err  = 1'($urandom_range(0, 1));
            end
            #3;
            lastReqFire = bus.imem_req_valid && bus.imem_req_ready;
            lastRspFire = bus.imem_rsp_valid && bus.imem_rsp_ready;
            lastAddr    = bus.imem_req_addr;
            if (holdReq && !rst && (!bus.imem_req_valid || bus.imem_req_addr !== heldAddr)) holdErr++;
            holdReq  = bus.imem_req_valid && !bus.imem_req_ready && !rst;
            heldAddr = bus.imem_req_addr;
        end
    end

    task automatic tick();
        @(negedge clk);
        #3;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic waitOutValid(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) checkOutput({name, " out_valid timeout"}, 32'(bus.out_valid), 32'd1);
    endtask

    task automatic consume(input string name);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        expCount++;
        checkOutput({name, " fetch_count"}, bus.fetch_count, 32'(expCount));
        checkOutput({name, " out_valid drop"}, 32'(bus.out_valid), 32'd0);
    endtask

    // One full transaction from the S_WAIT state: hand over npc, fetch, deliver.
    task automatic applyStimulus(input vec_t v, input string name);
        bit          ok;
        bit          stable;
        int          r0;
        logic [31:0] hp;
        logic [31:0] hi;
        logic        hf;
        cfgStall = v.memStall;
        cfgLat   = v.memLat;
        r0       = reqCount;
        bus.npc_valid = 1'b1;
        bus.npc       = v.npc;
        tick();
        bus.npc_valid = 1'b0;
        bus.npc       = $urandom;
        waitOutValid(name, ok);
        if (!ok) return;
        checkOutput({name, " out_pc"}, bus.out_pc, v.expPc);
        checkOutput({name, " out_inst"}, bus.out_inst, v.expInst);
        checkOutput({name, " out_fault"}, 32'(bus.out_fault), 32'(v.expFault));
        checkOutput({name, " req transfers"}, 32'(reqCount - r0), 32'(v.expReq));
        if (v.expReq != 0) checkOutput({name, " req addr"}, lastReqAddr, v.npc);
        hp = bus.out_pc; hi = bus.out_inst; hf = bus.out_fault;
        stable = 1'b1;
        for (int i = 0; i < v.outStall; i++) begin
            tick();
            if (!bus.out_valid || bus.out_pc !== hp || bus.out_inst !== hi ||
                bus.out_fault !== hf || bus.fetch_count !== 32'(expCount)) stable = 1'b0;
        end
        if (v.outStall > 0) checkOutput({name, " out stable"}, 32'(stable), 32'd1);
        consume(name);
    endtask

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks %0d/%0d", passCount, checkCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : mainTest
        bit          ok;
        bit          stable;
        int          lat;
        int          r0;
        logic [31:0] hp;
        logic [31:0] hi;
        vec_t        v;

        vecs[0] = '{32'h8000_0006, 0, 1, 0, 32'h8000_0006, 32'h0000_0000, 1'b1, 0};
        vecs[1] = '{32'h8000_E000, 3, 1, 1, 32'h8000_E000, 32'h0000_0000, 1'b1, 1};
        vecs[2] = '{32'h8000_0040, 0, 3, 2, 32'h8000_0040, 32'h0040_0413, 1'b0, 1};
        vecs[3] = '{32'h8000_1002, 0, 1, 0, 32'h8000_1002, 32'h0000_0000, 1'b1, 0};
        vecs[4] = '{32'h8000_0FFC, 2, 2, 0, 32'h8000_0FFC, 32'h0FFC_0413, 1'b0, 1};
        vecs[5] = '{32'h8000_D004, 0, 1, 1, 32'h8000_D004, 32'h0000_0013, 1'b0, 1};
        vecs[6] = '{32'hFFFF_FFFC, 1, 1, 1, 32'hFFFF_FFFC, 32'hFFFC_0413, 1'b0, 1};
        vecs[7] = '{32'h8000_EFF8, 0, 2, 3, 32'h8000_EFF8, 32'h0000_0000, 1'b1, 1};

        rst = 1'b1;
        bus.out_ready = 1'b0;
        bus.npc_valid = 1'b0;
        bus.npc       = '0;
        repeat (3) tick();

        checkOutput("reset req_valid", 32'(bus.imem_req_valid), 32'd0);
        checkOutput("reset rsp_ready", 32'(bus.imem_rsp_ready), 32'd0);
        checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset out_pc", bus.out_pc, 32'h0);
        checkOutput("reset out_inst", bus.out_inst, 32'h0);
        checkOutput("reset out_fault", 32'(bus.out_fault), 32'd0);
        checkOutput("reset fetch_count", bus.fetch_count, 32'd0);

        // First fetch from the reset pc and its request-to-output latency.
        rst = 1'b0;
        #1;
        checkOutput("boot req_valid", 32'(bus.imem_req_valid), 32'd1);
        checkOutput("boot req_addr", bus.imem_req_addr, 32'h8000_0000);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("boot req transfer seen", 32'(ok), 32'd1);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            lat++;
            if (bus.out_valid) break;
        end
        checkOutput("boot req->out latency", 32'(lat), 32'd2);
        checkOutput("boot out_pc", bus.out_pc, 32'h8000_0000);
        checkOutput("boot out_inst", bus.out_inst, 32'h0000_0413);
        checkOutput("boot out_fault", 32'(bus.out_fault), 32'd0);
        checkOutput("boot req addr seen", lastReqAddr, 32'h8000_0000);

        // Decode back-pressure for five cycles.
        hp = bus.out_pc; hi = bus.out_inst;
        stable = 1'b1;
        r0 = reqCount;
        repeat (5) begin
            tick();
            if (!bus.out_valid || bus.out_pc !== hp || bus.out_inst !== hi ||
                bus.imem_req_valid || bus.fetch_count !== 32'd0) stable = 1'b0;
        end
        checkOutput("stall payload stable", 32'(stable), 32'd1);
        checkOutput("stall no new req", 32'(reqCount - r0), 32'd0);
        consume("stall");

        // npc accepted in S_WAIT, ignored while still delivering.
        bus.npc_valid = 1'b1;
        bus.npc       = 32'h8000_0010;
        tick();
        bus.npc_valid = 1'b0;
        checkOutput("npc req_valid", 32'(bus.imem_req_valid), 32'd1);
        checkOutput("npc req_addr", bus.imem_req_addr, 32'h8000_0010);
        waitOutValid("npc", ok);
        checkOutput("npc out_inst", bus.out_inst, 32'h0010_0413);
        r0 = reqCount;
        bus.npc_valid = 1'b1;
        bus.npc       = 32'h8000_0020;
        repeat (3) tick();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.npc_valid = 1'b0;
        expCount++;
        repeat (3) tick();
        checkOutput("early npc ignored req_valid", 32'(bus.imem_req_valid), 32'd0);
        checkOutput("early npc ignored req count", 32'(reqCount - r0), 32'd0);
        checkOutput("early npc fetch_count", bus.fetch_count, 32'(expCount));

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 25; i++) begin
            v.npc = {16'h8000, 14'($urandom), 2'b00};
            case ($urandom_range(0, 9))
                0:       v.npc[1:0]   = 2'($urandom_range(1, 3));
                1:       v.npc[15:12] = 4'hE;
                2:       v.npc[15:12] = 4'hD;
                default: ;
            endcase
            v.memStall = $urandom_range(0, 3);
            v.memLat   = $urandom_range(1, 3);
            v.outStall = $urandom_range(0, 3);
            v.expPc    = v.npc;
            v.expInst  = refInst(v.npc);
            v.expFault = refFault(v.npc);
            v.expReq   = (v.npc[1:0] == 2'b00) ? 1 : 0;
            applyStimulus(v, $sformatf("rand%0d", i));
        end

        checkOutput("req held stable until accepted", 32'(holdErr), 32'd0);

        // Reset while a response is outstanding.
        cfgStall = 0;
        cfgLat   = 4;
        bus.npc_valid = 1'b1;
        bus.npc       = 32'h8000_0100;
        tick();
        bus.npc_valid = 1'b0;
        tick();
        checkOutput("midreset in S_RSP", 32'(bus.imem_rsp_ready), 32'd1);
        rst = 1'b1;
        tick();
        checkOutput("midreset rsp_ready", 32'(bus.imem_rsp_ready), 32'd0);
        checkOutput("midreset req_valid", 32'(bus.imem_req_valid), 32'd0);
        checkOutput("midreset out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("midreset fetch_count", bus.fetch_count, 32'd0);
        checkOutput("midreset pc", bus.imem_req_addr, 32'h8000_0000);
        rst = 1'b0;
        cfgLat = 1;
        expCount = 0;
        #1;
        checkOutput("midreset refetch req_valid", 32'(bus.imem_req_valid), 32'd1);
        waitOutValid("midreset refetch", ok);
        checkOutput("midreset refetch out_pc", bus.out_pc, 32'h8000_0000);
        checkOutput("midreset refetch out_inst", bus.out_inst, 32'h0000_0413);
        consume("midreset refetch");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
